// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues fetches, commits next PC.
// Optional retired-instruction counter: define PC_FETCH_CTRL_PERF_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] curr_pc,
    output logic        pc_ena,
    input  logic [31:0] next_pc,
    input  logic        exec_done,
    input  logic        halt_req,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [31:0] instret_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [7:0]  wait_cnt;
    logic [1:0]  err_q;

    logic in_idle;
    logic in_fetch;
    logic in_exec;
    logic in_halt;
    logic timeout;
    logic misalign;

    assign in_idle  = (state == IDLE);
    assign in_fetch = (state == FETCH);
    assign in_exec  = (state == EXEC);
    assign in_halt  = (state == HALT);

    assign timeout  = (wait_cnt == WAIT_LAST);
    assign misalign = (next_pc[1:0] != 2'b00);

    // Handshake outputs come from registered state only.
    assign imem_req   = in_fetch;
    assign imem_addr  = pc;
    assign inst_valid = in_exec;
    assign pc_ena     = in_exec;
    assign halted     = in_halt;
    assign inst       = inst_q;
    assign curr_pc    = pc;
    assign err_code   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            inst_q   <= '0;
            wait_cnt <= '0;
            err_q    <= '0;
        end else begin
            unique case (1'b1)
                in_idle: begin
                    state <= FETCH;
                end
                in_fetch: begin
                    if (imem_ack) begin
                        inst_q   <= imem_rdata;
                        wait_cnt <= '0;
                        state    <= EXEC;
                    end else if (timeout) begin
                        err_q <= ERR_TIMEOUT;
                        state <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                in_exec: begin
                    // Halt request outranks a misaligned target.
                    if (exec_done) begin
                        if (halt_req) begin
                            state <= HALT;
                        end else if (misalign) begin
                            err_q <= ERR_MISALIGN;
                            state <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PC_FETCH_CTRL_PERF_EN
    logic        commit;
    logic [31:0] instret_q;

    assign commit = in_exec & exec_done & ~halt_req & ~misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_cnt = instret_q;
`else
    assign instret_cnt = 32'h0;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Multi-cycle instruction-fetch sequencer that owns the architectural PC register and drives the next-PC mux enable. It issues one instruction-memory request per instruction, holds the fetched instruction for decode/execute, and commits the mux-selected next PC when execute reports completion. It detects fetch timeout, misaligned targets and halt requests. It sits between the instruction memory port and the decode/execute stage, upstream of the next-PC mux.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- MAX_WAIT, 15, FETCH cycles without ack before timeout (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- inst_valid  out  1  inst/curr_pc valid for decode/execute
- inst  out  32  latched instruction
- curr_pc  out  32  PC of the held instruction
- pc_ena  out  1  enable to next-PC mux (high only in EXEC)
- next_pc  in  32  next-PC mux result
- exec_done  in  1  execute complete; next_pc valid
- halt_req  in  1  stop after current instruction (ebreak)
- halted  out  1  core stopped
- err_code  out  2  0 none, 1 fetch timeout, 2 misaligned next_pc
- instret_cnt  out  32  retired-instruction count (see Configuration)

## Operation
- Registers: state (IDLE, FETCH, EXEC, HALT), pc[31:0], inst[31:0], wait_cnt[7:0], err_code[1:0].
- IDLE: outputs quiet; unconditional → FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. If imem_ack: inst<=imem_rdata, wait_cnt<=0, → EXEC. Else if wait_cnt==MAX_WAIT-1: err_code<=1, → HALT. Else wait_cnt<=wait_cnt+1.
- EXEC: inst_valid=1, pc_ena=1. If exec_done:
  - if halt_req → HALT, pc unchanged, err_code unchanged (0);
  - else if next_pc[1:0]!=2'b00 → HALT, err_code<=2, pc unchanged;
  - else pc<=next_pc, instret increments, → FETCH.
- Without exec_done, EXEC holds indefinitely; inst and curr_pc stable.
- HALT: halted=1; terminal until rst. All inputs ignored.
- imem_ack outside FETCH is ignored. halt_req without exec_done has no effect.
- halt_req and misalignment together: halt wins, err_code stays 0.
- curr_pc = pc; imem_addr = pc.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, inst=0, wait_cnt=0, err_code=0, imem_req=0, inst_valid=0, pc_ena=0, halted=0, instret_cnt=0.
- Reset asserted mid-operation forces all of the above immediately (asynchronous); imem_req drops in the same cycle; an in-flight ack is discarded.
- First imem_req is in the 2nd cycle after reset release (IDLE lasts 1 cycle).
- imem_req, inst_valid, pc_ena, halted decode from registered state only; no combinational input→output path.
- Ack in the same cycle as req: inst_valid the next cycle. Minimum 2 cycles per instruction (FETCH 1 + EXEC 1).
- The new pc is visible on imem_addr the cycle after exec_done.
- Timeout: with no ack, HALT is entered after exactly MAX_WAIT FETCH cycles.

## Configuration
- PC_FETCH_CTRL_PERF_EN defined: 32-bit instret counter, reset 0, +1 per committed (non-halt, aligned) exec_done, wraps at 2^32; drives instret_cnt.
- Not defined: no counter logic; instret_cnt tied to 32'h0.

## Test plan
- Reset release, imem_ack=1 constant, exec_done=1 with next_pc=pc+4 → imem_addr 0x80000000, 0x80000004, 0x80000008 on every other cycle; first req in cycle 2.
- imem_ack delayed 3 cycles, imem_rdata=0x00100093 → inst=0x00100093 and inst_valid 1 cycle after the ack; imem_req held the whole wait.
- No ack, MAX_WAIT=15 → after 15 FETCH cycles halted=1, err_code=1, imem_req=0.
- exec_done with next_pc=0x80000102 → halted=1, err_code=2, curr_pc unchanged.
- exec_done with halt_req=1 and next_pc=0x80000010 → halted=1, err_code=0, pc unchanged; later acks ignored; with PERF_EN, instret_cnt not incremented by the halting instruction.
- rst pulsed while in EXEC (pc=0x80000040) → immediately pc=0x80000000, inst_valid=0, pc_ena=0; with PERF_EN, instret_cnt=0.
